seg_scan_capture: RTL and testbench
===================================

// Module: seg_scan_capture
// PURPOSE
//  Receive-side counterpart of the 8-digit multiplexed 7-segment driver: monitors the active-low
//  anode scan (d7..d0), segment lines {g,f,e,d,c,b,a} and dp. Reconstructs per-digit values into
//  a frame register. Used as an on-board loopback checker and a bench scoreboard front end.
// PARAMETERS
//  SETTLE   8        cycles of stable anode+segment inputs required before a digit is captured
//  TIMEOUT  2000000  cycles with no new capture before frame data is declared stale
// PORTS
//  clk          in   1   system clock (100 MHz)
//  rst_n        in   1   asynchronous, active-low reset
//  scan         in   8   anode lines {d7..d0}, active-low, one-hot-low when valid
//  seg          in   7   segment lines {g,f,e,d,c,b,a}, active-low
//  dp           in   1   decimal point, active-low
//  digits       out  32  decoded codes, digit i at [4i+3:4i] (digit i = anode d_i)
//  blank_mask   out  8   bit i set: digit i showed all segments off
//  dp_mask      out  8   bit i set: digit i had dp lit
//  frame_valid  out  1   one-cycle pulse when all 8 digits captured since last pulse
//  glyph_err    out  1   one-cycle pulse on capture of an undecodable pattern
//  scan_err     out  1   one-cycle pulse when >1 anode is low for SETTLE cycles
//  stale        out  1   level: high while no capture for TIMEOUT cycles
// BEHAVIOUR
//  - Reset: all outputs 0, digits=0, blank_mask=8'hFF, seen-mask=0, FSM=IDLE, counters 0.
//  - Inputs pass a 2-flop synchronizer (16 bits); all decisions on synchronized values (+2 cyc).
//  - FSM IDLE: scan==8'hFF or any change -> stay/restart; one-hot-low scan -> SETTLE, cnt=0.
//  - SETTLE: cnt++ while {scan,seg,dp} unchanged; any change -> restart SETTLE (cnt=0) or IDLE if
//    not one-hot-low. cnt==SETTLE-1 -> CAPTURE.
//  - CAPTURE (1 cycle): write code/blank/dp for the active digit, set seen[i]; -> HOLD.
//  - HOLD: wait for any {scan,seg,dp} change, then re-evaluate as IDLE. Same digit never captured
//    twice without an input change.
//  - Multiple anodes low, stable SETTLE cycles: scan_err pulse once, no capture, -> HOLD.
//  - Decode table (seg, g..a): 0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010
//    6:0000010 7:1111000 or 1011000 8:0000000 9:0010000; 1111111 -> blank (code 0, blank bit=1).
//  - Unlisted pattern: code 4'hF, blank bit=0, glyph_err pulse; digit still marked seen.
//  - Frame: when seen becomes 8'hFF, frame_valid pulses in the cycle after CAPTURE; seen clears
//    the same cycle. digits/blank_mask/dp_mask hold last values (not cleared per frame).
//  - Stale: timer cleared on every CAPTURE, saturates at TIMEOUT; stale=1 at saturation, clears
//    on next CAPTURE. At stale assertion seen clears (partial frame discarded).
//  - Reset mid-operation: async clear of everything above; first frame_valid needs 8 fresh caps.
//  - Simultaneous CAPTURE and timeout: CAPTURE wins, timer cleared, stale stays/goes 0.
// CONFIGURATION
//  SEG_HEX_DECODE_EN defined: additionally decode A:0001000 b:0000011 C:1000110 d:0100001
//    E:0000110 F:0001110 to 4'hA..4'hF with no glyph_err; 4'hF then means only "F" glyph.
//  Undefined: those patterns are unlisted -> code 4'hF + glyph_err (as above).
// TESTING
//  1 Drive scan=8'b0111_1111, seg=7'b0100100 for 20 cyc -> digits[31:28]=2, blank_mask[7]=0.
//  2 Cycle d7..d0 with 1..8, 100 cyc each -> one frame_valid pulse, digits=32'h1234_5678.
//  3 Change seg every 5 cyc (SETTLE=8) on one digit -> no capture; digits unchanged.
//  4 scan=8'b0011_1111 stable 20 cyc -> one scan_err pulse, no digit update, seen unchanged.
//  5 seg=7'b0001000 on d0: without SEG_HEX_DECODE_EN -> digits[3:0]=F + glyph_err; with -> A.
//  6 Stop scan (8'hFF) TIMEOUT cyc -> stale=1; 3 caps then rst_n low 1 cyc -> all outputs reset.

Source files
------------

// File: rtl/seg_scan_capture.sv
// Receive-side monitor for an 8-digit multiplexed 7-segment scan: reconstructs digit codes into a frame.
// Optional macro SEG_HEX_DECODE_EN adds A..F glyph decoding.
module seg_scan_capture #(
    parameter int SETTLE  = 8,
    parameter int TIMEOUT = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  scan,
    input  logic [6:0]  seg,
    input  logic        dp,
    output logic [31:0] digits,
    output logic [7:0]  blank_mask,
    output logic [7:0]  dp_mask,
    output logic        frame_valid,
    output logic        glyph_err,
    output logic        scan_err,
    output logic        stale
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETTLING, CAPTURE, HOLD} state_t;

    // {code[3:0], blank, err}
    function automatic logic [5:0] decode(input logic [6:0] s);
        logic [5:0] r;
        r = {4'hF, 1'b0, 1'b1};
        case (s)
            7'b1000000: r = {4'h0, 2'b00};
            7'b1111001: r = {4'h1, 2'b00};
            7'b0100100: r = {4'h2, 2'b00};
            7'b0110000: r = {4'h3, 2'b00};
            7'b0011001: r = {4'h4, 2'b00};
            7'b0010010: r = {4'h5, 2'b00};
            7'b0000010: r = {4'h6, 2'b00};
            7'b1111000,
            7'b1011000: r = {4'h7, 2'b00};
            7'b0000000: r = {4'h8, 2'b00};
            7'b0010000: r = {4'h9, 2'b00};
            7'b1111111: r = {4'h0, 2'b10};
`ifdef SEG_HEX_DECODE_EN
            7'b0001000: r = {4'hA, 2'b00};
            7'b0000011: r = {4'hB, 2'b00};
            7'b1000110: r = {4'hC, 2'b00};
            7'b0100001: r = {4'hD, 2'b00};
            7'b0000110: r = {4'hE, 2'b00};
            7'b0001110: r = {4'hF, 2'b00};
`else
`endif
            default:    r = {4'hF, 1'b0, 1'b1};
        endcase
        return r;
    endfunction

    logic [15:0]   sync1, sync2, prev;
    logic [7:0]    cur_scan;
    logic          changed, any_low, one_low;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          cnt_clr, cnt_inc, do_cap, scan_err_set;
    logic [TW-1:0] timer;
    logic [7:0]    seen, cap_bit, seen_nxt;
    logic [5:0]    dec;

    // prev trails sync2 by one cycle; in CAPTURE it holds the settled pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= {scan, seg, dp};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign cur_scan = sync2[15:8];
    assign changed  = (sync2 != prev);
    assign any_low  = (cur_scan != 8'hFF);
    assign one_low  = $onehot(~cur_scan);
    assign cap_bit  = ~prev[15:8];
    assign seen_nxt = seen | cap_bit;
    assign dec      = decode(prev[7:1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        do_cap       = 1'b0;
        scan_err_set = 1'b0;
        case (state)
            IDLE: begin
                if (!changed && any_low) begin
                    state_nxt = SETTLING;
                    cnt_clr   = 1'b1;
                end
            end
            SETTLING: begin
                if (changed) begin
                    state_nxt = any_low ? SETTLING : IDLE;
                    cnt_clr   = 1'b1;
                end else if (cnt == CW'(SETTLE - 1)) begin
                    // several anodes low and stable: flag once, then wait for movement
                    if (one_low) state_nxt = CAPTURE;
                    else begin
                        state_nxt    = HOLD;
                        scan_err_set = 1'b1;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            CAPTURE: begin
                do_cap    = 1'b1;
                state_nxt = changed ? IDLE : HOLD;
            end
            HOLD: begin
                if (changed) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= '0;
            blank_mask  <= 8'hFF;
            dp_mask     <= '0;
            frame_valid <= 1'b0;
            glyph_err   <= 1'b0;
            scan_err    <= 1'b0;
            stale       <= 1'b0;
            seen        <= '0;
            timer       <= '0;
        end else begin
            frame_valid <= 1'b0;
            glyph_err   <= 1'b0;
            scan_err    <= scan_err_set;
            if (do_cap) begin
                for (int i = 0; i < 8; i++) begin
                    if (cap_bit[i]) begin
                        digits[4*i +: 4] <= dec[5:2];
                        blank_mask[i]    <= dec[1];
                        dp_mask[i]       <= ~prev[0];
                    end
                end
                glyph_err <= dec[0];
                timer     <= '0;
                stale     <= 1'b0;
                if (seen_nxt == 8'hFF) begin
                    frame_valid <= 1'b1;
                    seen        <= '0;
                end else begin
                    seen <= seen_nxt;
                end
            end else if (timer != TW'(TIMEOUT)) begin
                timer <= timer + 1'b1;
                // partial frame is discarded once the scan goes quiet
                if (timer == TW'(TIMEOUT - 1)) begin
                    stale <= 1'b1;
                    seen  <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed-vector bench for seg_scan_capture (TIMEOUT shortened to 300).
module tb_seg_scan_capture;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  scan = 8'hFF;
    logic [6:0]  seg = 7'h7F;
    logic        dp = 1'b1;
    logic [31:0] digits;
    logic [7:0]  blank_mask, dp_mask;
    logic        frame_valid, glyph_err, scan_err, stale;

    int n_chk = 0, n_err = 0;
    int n_fv = 0, n_ge = 0, n_se = 0;

    seg_scan_capture #(.SETTLE(8), .TIMEOUT(300)) dut (
        .clk(clk), .rst_n(rst_n), .scan(scan), .seg(seg), .dp(dp),
        .digits(digits), .blank_mask(blank_mask), .dp_mask(dp_mask),
        .frame_valid(frame_valid), .glyph_err(glyph_err), .scan_err(scan_err),
        .stale(stale)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) n_fv++;
        if (glyph_err === 1'b1)   n_ge++;
        if (scan_err === 1'b1)    n_se++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // show one digit long enough to capture, then blank the scan briefly
    task automatic cap(input int idx, input logic [6:0] s, input logic d);
        logic [7:0] one;
        one  = 8'h01 << idx;
        scan = ~one;
        seg  = s;
        dp   = d;
        step(30);
        scan = 8'hFF;
        seg  = 7'h7F;
        dp   = 1'b1;
        step(5);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_digits"}, digits, 32'h0);
        chk({tag, "_blank"}, {24'h0, blank_mask}, 32'hFF);
        chk({tag, "_dp"}, {24'h0, dp_mask}, 32'h0);
        chk({tag, "_flags"}, {28'h0, frame_valid, glyph_err, scan_err, stale}, 32'h0);
    endtask

    logic [6:0] seg_tab [0:7];
    logic [3:0] hexa;
    int         ge_exp;

    initial begin
        seg_tab[0] = 7'b1111001; seg_tab[1] = 7'b0100100; seg_tab[2] = 7'b0110000;
        seg_tab[3] = 7'b0011001; seg_tab[4] = 7'b0010010; seg_tab[5] = 7'b0000010;
        seg_tab[6] = 7'b1111000; seg_tab[7] = 7'b0000000;

        step(3);
        chk_reset("reset");
        rst_n = 1'b1;
        step(3);

        // single digit 2 on d7
        scan = 8'b0111_1111; seg = 7'b0100100; dp = 1'b1;
        step(20);
        chk("t1_d7", {28'h0, digits[31:28]}, 32'h2);
        chk("t1_blank7", {31'h0, blank_mask[7]}, 32'h0);
        scan = 8'hFF; seg = 7'h7F;
        step(5);

        // full scan: d7..d0 show 1..8, dp lit on d3
        for (int k = 0; k < 8; k++) begin
            scan = ~(8'h80 >> k);
            seg  = seg_tab[k];
            dp   = ((7 - k) == 3) ? 1'b0 : 1'b1;
            step(100);
        end
        scan = 8'hFF; seg = 7'h7F; dp = 1'b1;
        step(5);
        chk("t2_digits", digits, 32'h1234_5678);
        chk("t2_frames", n_fv, 1);
        chk("t2_blank", {24'h0, blank_mask}, 32'h0);
        chk("t2_dp", {24'h0, dp_mask}, 32'h08);

        // unstable segments on d0 never settle
        scan = 8'hFE;
        for (int k = 0; k < 8; k++) begin
            seg = (k % 2 == 0) ? 7'b1000000 : 7'b0010000;
            step(5);
        end
        scan = 8'hFF; seg = 7'h7F;
        step(5);
        chk("t3_digits", digits, 32'h1234_5678);
        chk("t3_glyph", n_ge, 0);

        // two anodes low
        scan = 8'b0011_1111; seg = 7'b0100100;
        step(20);
        scan = 8'hFF; seg = 7'h7F;
        step(5);
        chk("t4_scan_err", n_se, 1);
        chk("t4_digits", digits, 32'h1234_5678);
        chk("t4_frames", n_fv, 1);

        // hex glyph A on d0, unlisted on d1, blank on d2, alt 7 on d4
`ifdef SEG_HEX_DECODE_EN
        hexa = 4'hA; ge_exp = 1;
`else
        hexa = 4'hF; ge_exp = 2;
`endif
        cap(0, 7'b0001000, 1'b1);
        chk("t5_d0", {28'h0, digits[3:0]}, {28'h0, hexa});
        cap(1, 7'b1010101, 1'b1);
        cap(2, 7'b1111111, 1'b1);
        cap(4, 7'b1011000, 1'b1);
        chk("t5_digits", digits, {28'h1237_50F, hexa});
        chk("t5_glyph", n_ge, ge_exp);
        chk("t5_blank", {24'h0, blank_mask}, 32'h04);
        chk("t5_stale0", {31'h0, stale}, 32'h0);

        // quiet scan -> stale; 4 later caps must not complete the discarded frame
        step(320);
        chk("t6_stale", {31'h0, stale}, 32'h1);
        cap(3, 7'b0110000, 1'b1);
        chk("t6_stale_clr", {31'h0, stale}, 32'h0);
        cap(5, 7'b0000010, 1'b1);
        cap(6, 7'b0000000, 1'b1);
        cap(7, 7'b0010000, 1'b1);
        chk("t6_digits", digits, {28'h9867_30F, hexa});
        chk("t6_frames", n_fv, 1);

        // mid-operation reset
        rst_n = 1'b0;
        #2;
        chk_reset("t6_rst");
        step(1);
        rst_n = 1'b1;
        step(2);
        for (int k = 0; k < 7; k++) cap(k, 7'b1000000, 1'b1);
        chk("t7_partial", n_fv, 1);
        cap(7, 7'b1000000, 1'b1);
        chk("t7_frames", n_fv, 2);
        chk("t7_digits", digits, 32'h0);
        chk("t7_blank", {24'h0, blank_mask}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
